// File: rtl/pc_select_dreg.sv
// Y86-64 front-end: PC select, next-PC prediction,
// fetch status and the F/D pipeline registers.
module pc_select_dreg #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_instr_valid,
  input  logic        f_imem_error,
  input  logic        f_hlt,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  output logic [63:0] f_pc,
  output logic [63:0] f_predPC,
  output logic [63:0] F_predPC,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] R_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    R_NONE,
    rb:    R_NONE,
    valc:  64'd0,
    valp:  64'd0
  };

  d_reg_t d_q;
  d_reg_t d_nxt;
  logic [2:0] f_stat;

  // PC select: mispredicted jXX beats returning ret
  always_comb begin
    f_pc = F_predPC;
    if (M_icode == I_JXX && !M_Cnd)
      f_pc = M_valA;
    else if (W_icode == I_RET)
      f_pc = W_valM;
  end

  // Always predict taken for jumps and calls
  always_comb begin
    f_predPC = f_valP;
    if (f_icode == I_JXX || f_icode == I_CALL)
      f_predPC = f_valC;
  end

  // Fetch status, ADR > INS > HLT > AOK
  always_comb begin
    f_stat = S_AOK;
    if (f_imem_error)
      f_stat = S_ADR;
    else if (!f_instr_valid)
      f_stat = S_INS;
    else if (f_hlt || f_icode == I_HALT)
      f_stat = S_HLT;
  end

  // Clean unused fields before they enter decode
  always_comb begin
    d_nxt       = '0;
    d_nxt.stat  = f_stat;
    d_nxt.icode = f_icode;
    d_nxt.ifun  = (f_stat == S_AOK) ? f_ifun : 4'h0;
    d_nxt.ra    = f_rA;
    d_nxt.rb    = f_rB;
    d_nxt.valc  = 64'd0;
    d_nxt.valp  = f_valP;
    unique case (f_icode)
      I_HALT, I_NOP, I_IRMOV,
      I_JXX, I_CALL, I_RET: d_nxt.ra = R_NONE;
      default:              d_nxt.ra = f_rA;
    endcase
    unique case (f_icode)
      I_HALT, I_NOP, I_JXX, I_CALL,
      I_RET, I_PUSH, I_POP: d_nxt.rb = R_NONE;
      default:              d_nxt.rb = f_rB;
    endcase
    unique case (f_icode)
      I_IRMOV, I_RMMOV, I_MRMOV,
      I_JXX, I_CALL: d_nxt.valc = f_valC;
      default:       d_nxt.valc = 64'd0;
    endcase
  end

  // F register: predicted PC, held on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      F_predPC <= RESET_PC;
    else if (!F_stall)
      F_predPC <= f_predPC;
  end

  // D register: stall holds, bubble injects a nop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      d_q <= D_BUBBLE;
    else if (D_stall)
      d_q <= d_q;
    else if (D_bubble)
      d_q <= D_BUBBLE;
    else
      d_q <= d_nxt;
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

// File: doc/pc_select_dreg.md
Name: pc_select_dreg

Overview:
- Front-end glue around the Y86-64 pipelined fetch stage.
- Holds the F pipeline register (predicted PC) and selects the PC presented to fetch: redirects on a mispredicted jXX or a completed ret.
- Predicts the next PC from the fetched instruction.
- Computes the fetch status code.
- Latches normalised fetch outputs into the D pipeline register with stall/bubble control.

Parameters:
- RESET_PC, 64'd0, F_predPC value after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- f_icode  in  4  icode decoded at f_pc.
- f_ifun  in  4  ifun decoded at f_pc.
- f_rA  in  4  rA field from fetch.
- f_rB  in  4  rB field from fetch.
- f_valC  in  64  constant word from fetch.
- f_valP  in  64  fall-through PC from fetch.
- f_instr_valid  in  1  icode legal.
- f_imem_error  in  1  PC out of instruction memory.
- f_hlt  in  1  halt fetched.
- M_icode  in  4  icode in M stage.
- M_Cnd  in  1  branch condition evaluated in E, carried in M.
- M_valA  in  64  fall-through PC of jXX in M.
- W_icode  in  4  icode in W stage.
- W_valM  in  64  return address loaded by ret.
- F_stall  in  1  hold F_predPC.
- D_stall  in  1  hold D register.
- D_bubble  in  1  load nop bubble into D.
- f_pc  out  64  PC to fetch (combinational).
- f_predPC  out  64  next predicted PC (combinational).
- F_predPC  out  64  F register.
- D_stat  out  3  status: AOK=1, HLT=2, ADR=3, INS=4.
- D_icode  out  4  D register icode.
- D_ifun  out  4  D register ifun.
- D_rA  out  4  D register rA.
- D_rB  out  4  D register rB.
- D_valC  out  64  D register valC.
- D_valP  out  64  D register valP.

Behaviour:
- f_* inputs are the decode of f_pc in the same cycle: combinational fetch path, no added latency.
- icodes: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OP=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
- PC select, priority order:
  1. M_icode==JXX && !M_Cnd → f_pc=M_valA.
  2. Else W_icode==RET → f_pc=W_valM.
  3. Else f_pc=F_predPC.
  - When both redirect conditions hold, the mispredict wins.
- Prediction: f_icode in {JXX, CALL} → f_predPC=f_valC; otherwise f_valP. Taken-branch prediction is always used.
- Status, priority ADR > INS > HLT > AOK:
  - f_imem_error → ADR.
  - Else !f_instr_valid → INS.
  - Else f_hlt or f_icode==HALT → HLT.
  - Else AOK.
- Normalisation before the D capture (the fetch outputs may be stale for unused fields):
  - rA forced to 0xF for HALT, NOP, IRMOV, JXX, CALL, RET.
  - rB forced to 0xF for HALT, NOP, JXX, CALL, RET, PUSH, POP.
  - valC forced to 0 unless icode in {IRMOV, RMMOV, MRMOV, JXX, CALL}.
  - If status ≠ AOK, ifun is forced to 0; icode passes through unchanged.
- F register, each posedge: F_stall → hold; else F_predPC←f_predPC.
- D register, each posedge:
  - D_stall → hold all fields. Stall beats bubble when both are asserted.
  - Else D_bubble → load bubble: stat=AOK, icode=NOP, ifun=0, rA=rB=F, valC=0, valP=0.
  - Else → load normalised fetch fields, status and f_valP.
- Reset (rst_n low, asynchronous, any time including mid-stall): F_predPC=RESET_PC; D register = bubble values.
- After reset release, the first posedge captures the instruction at RESET_PC.
- Widths: all PC arithmetic is 64-bit modulo; no overflow detection. ADR comes only from f_imem_error.
- No internal halt freeze; pipeline control (hazard unit) is responsible for stopping fetch after a non-AOK status.

Test Plan:
- Reset: rst_n=0 mid-cycle → F_predPC=0, D_icode=1, D_rA=D_rB=F, D_stat=1 immediately. Release, then f_icode=6, f_rA=2, f_rB=3, f_valP=2 → next edge D_icode=6, D_rA=2, D_rB=3, F_predPC=2.
- Call prediction: f_icode=8, f_valC=0x40, f_valP=0x34 → F_predPC=0x40, D_valP=0x34, D_rA=D_rB=F.
- Mispredict + ret together: M_icode=7, M_Cnd=0, M_valA=0x2B, W_icode=9, W_valM=0x80 → f_pc=0x2B. Then M_Cnd=1 → f_pc=0x80.
- Status priority: f_imem_error=1, f_instr_valid=0 → D_stat=3. Then f_instr_valid=0 only → 4. Then f_icode=0 → 2, D_ifun=0.
- Stall/bubble: D_stall=1 with D_bubble=1 → D register unchanged. D_bubble=1 only → D_icode=1, D_valC=0. F_stall=1 → F_predPC holds for 3 cycles.
- Normalisation: f_icode=3, f_rA=5, f_valC=0x11 → D_rA=F, D_valC=0x11. f_icode=6, f_valC=0x99 → D_valC=0.
